calc_result_stage: RTL and testbench
====================================

Name: calc_result_stage

Overview:
- Downstream stage of the 3-bit sign-magnitude remainder unit.
- Captures remainder R2..R0 and divisor B2..B0 through a valid/ready handshake.
- Normalises negative zero and derives the ZF/EF/OF/DZF flags, then holds the result for the consumer.
- Drives a 2-digit time-multiplexed 7-segment display (sign digit, magnitude digit).

Parameters:
REFRESH_DIV, 16, clock cycles per display digit slot; legal values ≥ 2.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
R2  input  1  remainder sign bit (1 = negative)
R1  input  1  remainder magnitude bit 1
R0  input  1  remainder magnitude bit 0
B2  input  1  divisor sign bit
B1  input  1  divisor magnitude bit 1
B0  input  1  divisor magnitude bit 0
in_valid  input  1  R and B inputs valid
in_ready  output  1  stage can accept a result
out_valid  output  1  held result and flags valid
out_ready  input  1  consumer accepts the held result
Q2  output  1  held sign bit, normalised
Q1  output  1  held magnitude bit 1
Q0  output  1  held magnitude bit 0
ZF  output  1  zero flag
EF  output  1  even flag
OF  output  1  odd flag
DZF  output  1  divide-by-zero flag
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
an  output  2  digit enables, active-low; an[1] = sign digit, an[0] = magnitude digit

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; out_valid = 0; in_ready = 1.
  - Q2..Q0 = 000; ZF/EF/OF/DZF = 0.
  - Refresh counter = 0; digit select = 0, so an = 2'b10.
  - seg = 7'b1111111 (blank); display-loaded flag cleared.
- FSM has two states, IDLE and HOLD:
  - in_ready = (state == IDLE); out_valid = (state == HOLD). Both are combinational from state.
  - IDLE -> HOLD when in_valid && in_ready. On that edge, capture:
    - mag = {R1,R0}
    - Q2 = R2 && (mag != 0), so negative zero normalises to +0
    - {Q1,Q0} = mag
    - ZF = (mag == 0)
    - EF = ~R0
    - OF = R0
    - DZF = ({B1,B0} == 0), independent of B2
    - set display-loaded flag
  - Latency: out_valid rises in the cycle after the capture edge.
  - HOLD -> IDLE when out_ready. Q and flags keep their values after the transfer (out_valid = 0). The display keeps showing the last result until the next capture.
  - in_valid is ignored in HOLD: no pass-through. The upstream stage holds its data. Maximum throughput is one result per 2 cycles.
  - out_ready is ignored in IDLE.
  - Q and flags are stable for the whole HOLD period.
- Display:
  - Refresh counter counts 0..REFRESH_DIV-1. On the wrap edge, digit select toggles.
  - sel = 0: an = 2'b10, seg shows the magnitude digit.
  - sel = 1: an = 2'b01, seg shows the sign digit.
  - Encodings: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, minus = 0111111, E = 0000110, blank = 1111111.
  - Before the first capture after reset: both digits blank.
  - DZF = 1: magnitude digit = E, sign digit = blank.
  - Otherwise: sign digit = minus if Q2, else blank; magnitude digit = {Q1,Q0}.
  - seg and an are registered and update in the same cycle as sel.
- Flags are computed only from the captured values, never from live inputs.
- Reset mid-HOLD: the result is discarded, the display blanks, and the FSM returns to IDLE immediately.

Test Plan:
- Reset release -> in_ready = 1, out_valid = 0, flags 0000, seg = 1111111 on both digits for at least 2*REFRESH_DIV cycles.
- R = 110 (-2), B = 011, in_valid pulse -> next cycle out_valid = 1, Q = 110, ZF/EF/OF/DZF = 0100, sign digit 0111111, magnitude digit 0100100.
- R = 100 (-0), B = 001 -> Q = 000, ZF = 1, EF = 1, OF = 0; sign digit blank, magnitude digit 1000000.
- R = 000, B = 100 (-0 divisor) -> DZF = 1, ZF = 1; magnitude digit 0000110.
- Hold out_ready = 0 for 10 cycles with in_valid = 1 and changing R -> Q/flags unchanged, in_ready = 0. Then out_ready = 1 for 1 cycle -> IDLE, next in_valid captures the new value.
- Assert rst_n = 0 mid-HOLD -> out_valid falls immediately, seg blank. After release, an alternates every REFRESH_DIV cycles starting with 2'b10.

Source files
------------

// File: rtl/calc_result_stage.sv
// Result stage of the 3-bit sign-magnitude remainder unit: captures R/B over a valid/ready
// handshake, derives ZF/EF/OF/DZF and drives a two-digit multiplexed 7-segment display.
module calc_result_stage #(
  parameter int unsigned REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       R2,
  input  logic       R1,
  input  logic       R0,
  input  logic       B2,
  input  logic       B1,
  input  logic       B0,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       Q2,
  output logic       Q1,
  output logic       Q0,
  output logic       ZF,
  output logic       EF,
  output logic       OF,
  output logic       DZF,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegMinus = 7'b0111111;
  localparam logic [6:0] SegE     = 7'b0000110;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e          state_q, state_d;
  logic            q2_q, q2_d;
  logic [1:0]      mag_q, mag_d;
  logic            zf_q, zf_d;
  logic            ef_q, ef_d;
  logic            of_q, of_d;
  logic            dzf_q, dzf_d;
  logic            loaded_q, loaded_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_q, sel_d;
  logic [6:0]      seg_q, seg_d;
  logic [1:0]      an_q, an_d;

  logic            accept;
  logic [1:0]      in_mag;

  // B2 is unused: a divisor of -0 is still a divide-by-zero.
  logic            unused_b2;
  assign unused_b2 = B2;

  function automatic logic [6:0] digit_seg(input logic [1:0] v);
    logic [6:0] s;
    unique case (v)
      2'd0:    s = 7'b1000000;
      2'd1:    s = 7'b1111001;
      2'd2:    s = 7'b0100100;
      2'd3:    s = 7'b0110000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid && in_ready;
  assign in_mag    = {R1, R0};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StHold;
      StHold:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    q2_d     = q2_q;
    mag_d    = mag_q;
    zf_d     = zf_q;
    ef_d     = ef_q;
    of_d     = of_q;
    dzf_d    = dzf_q;
    loaded_d = loaded_q;
    if (accept) begin
      q2_d     = R2 && (in_mag != 2'd0);
      mag_d    = in_mag;
      zf_d     = (in_mag == 2'd0);
      ef_d     = ~R0;
      of_d     = R0;
      dzf_d    = ({B1, B0} == 2'b00);
      loaded_d = 1'b1;
    end
  end

  // Display is built from next-state values so seg/an change on the same edge as sel.
  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    sel_d = sel_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      sel_d = ~sel_q;
    end
    an_d = sel_d ? 2'b01 : 2'b10;
    if (!loaded_d) begin
      seg_d = SegBlank;
    end else if (sel_d) begin
      seg_d = (!dzf_d && q2_d) ? SegMinus : SegBlank;
    end else begin
      seg_d = dzf_d ? SegE : digit_seg(mag_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      q2_q     <= 1'b0;
      mag_q    <= 2'b00;
      zf_q     <= 1'b0;
      ef_q     <= 1'b0;
      of_q     <= 1'b0;
      dzf_q    <= 1'b0;
      loaded_q <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      seg_q    <= SegBlank;
      an_q     <= 2'b10;
    end else begin
      state_q  <= state_d;
      q2_q     <= q2_d;
      mag_q    <= mag_d;
      zf_q     <= zf_d;
      ef_q     <= ef_d;
      of_q     <= of_d;
      dzf_q    <= dzf_d;
      loaded_q <= loaded_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign Q2  = q2_q;
  assign Q1  = mag_q[1];
  assign Q0  = mag_q[0];
  assign ZF  = zf_q;
  assign EF  = ef_q;
  assign OF  = of_q;
  assign DZF = dzf_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_calc_result_stage.sv
// Scoreboard bench for calc_result_stage: expected results are queued at drive time and
// compared when out_valid rises; the display is checked against a refresh model every cycle.
module tb_calc_result_stage;

  localparam int unsigned Div = 4;

  logic       clk, rst_n;
  logic       r2, r1, r0, b2, b1, b0;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic       q2, q1, q0, zf, ef, of_o, dzf;
  logic [6:0] seg;
  logic [1:0] an;

  typedef struct packed {
    logic [2:0] q;
    logic [3:0] f;  // {ZF, EF, OF, DZF}
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  logic disp_loaded;
  logic ov_prev;
  int   total = 0;
  int   bad = 0;
  int   mcnt;
  logic msel;

  calc_result_stage #(.REFRESH_DIV(Div)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .R2        (r2),
    .R1        (r1),
    .R0        (r0),
    .B2        (b2),
    .B1        (b1),
    .B0        (b0),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q2        (q2),
    .Q1        (q1),
    .Q0        (q0),
    .ZF        (zf),
    .EF        (ef),
    .OF        (of_o),
    .DZF       (dzf),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic sel, input logic ld, input exp_t e);
    logic [6:0] s;
    s = 7'b1111111;
    if (ld) begin
      if (sel) begin
        if (!e.f[0] && e.q[2]) s = 7'b0111111;
      end else if (e.f[0]) begin
        s = 7'b0000110;
      end else begin
        case (e.q[1:0])
          2'd0: s = 7'b1000000;
          2'd1: s = 7'b1111001;
          2'd2: s = 7'b0100100;
          default: s = 7'b0110000;
        endcase
      end
    end
    return s;
  endfunction

  // Refresh model: a digit slot lasts Div cycles, starting with the magnitude digit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt <= 0;
      msel <= 1'b0;
    end else if (mcnt == Div - 1) begin
      mcnt <= 0;
      msel <= ~msel;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  initial begin
    disp_loaded = 1'b0;
    ov_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        disp_loaded = 1'b0;
        ov_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'd1, 32'd0);
          end else begin
            held = exp_q.pop_front();
            disp_loaded = 1'b1;
            chk("q", {q2, q1, q0}, held.q);
            chk("flags", {zf, ef, of_o, dzf}, held.f);
          end
        end else if (out_valid) begin
          chk("q_hold", {q2, q1, q0, zf, ef, of_o, dzf}, {held.q, held.f});
        end
        chk("ready", in_ready, !out_valid);
        chk("an", an, msel ? 2'b01 : 2'b10);
        chk("seg", seg, model_seg(msel, disp_loaded, held));
        ov_prev = out_valid;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] r, input logic [2:0] b);
    exp_t e;
    logic hs;
    logic done;
    e.q = {r[2] && (r[1:0] != 2'b00), r[1:0]};
    e.f = {r[1:0] == 2'b00, ~r[0], r[0], b[1:0] == 2'b00};
    exp_q.push_back(e);
    {r2, r1, r0} = r;
    {b2, b1, b0} = b;
    in_valid = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      hs = in_ready;
      @(posedge clk);
      #1;
      done = hs;
    end
    if (!done) chk("handshake_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    chk("released", {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    {r2, r1, r0, b2, b1, b0} = '0;
    #23;
    chk("rst_hs", {in_ready, out_valid}, 2'b10);
    chk("rst_q_flags", {q2, q1, q0, zf, ef, of_o, dzf}, 7'd0);
    chk("rst_disp", {seg, an}, {7'b1111111, 2'b10});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycles(2 * Div + 2);

    send(3'b110, 3'b011);
    cycles(2 * Div + 2);
    consume();
    send(3'b100, 3'b001);
    cycles(2 * Div + 2);
    consume();
    send(3'b000, 3'b100);
    cycles(2 * Div + 2);
    consume();

    // Upstream keeps in_valid high with changing data while the consumer stalls.
    send(3'b011, 3'b010);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      {r2, r1, r0} = 3'($urandom_range(0, 7));
      {b2, b1, b0} = 3'($urandom_range(0, 7));
      chk("stall_ready", in_ready, 1'b0);
      cycles(1);
    end
    in_valid = 1'b0;
    consume();
    send(3'b101, 3'b111);
    cycles(2 * Div + 1);
    consume();

    for (int i = 0; i < 8; i++) begin
      send(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      cycles($urandom_range(0, 2 * Div));
      consume();
    end

    send(3'b111, 3'b001);
    cycles(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_hs", {in_ready, out_valid}, 2'b10);
    chk("midrst_disp", {seg, an}, {7'b1111111, 2'b10});
    cycles(2);
    rst_n = 1'b1;
    cycles(3 * Div + 2);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
